// File: rtl/pong_pkg.sv
// Shared pong datapath types and default playfield geometry.
// No ports; imported by the ball trajectory interface, top and axis sub-module.
// Optional feature macro used by users of this package: TRAJ_BOUNCE_COUNT_EN.
package pong_pkg;

  // Direction of travel along one axis
  typedef logic dir_t;

  localparam dir_t DIR_INC = 1'b1;
  localparam dir_t DIR_DEC = 1'b0;

  // Default playfield extents (inclusive)
  localparam int unsigned PF_X_MAX = 319;
  localparam int unsigned PF_Y_MAX = 239;

  localparam int unsigned BOUNCE_CNT_W = 16;

endpackage

// File: rtl/ball_trajectory_2d_if.sv
// Control/status bundle between the game controller and the ball trajectory block.
// master: controller side (drives active/threshold/serve, observes position and pulses).
// slave : trajectory block side.
// With TRAJ_BOUNCE_COUNT_EN defined the bundle also carries bounce_count.
interface ball_trajectory_2d_if #(
  parameter int unsigned X_W  = 9,
  parameter int unsigned Y_W  = 9,
  parameter int unsigned TH_W = 64
);

  logic                active;
  logic [TH_W-1:0]     threshold;
  logic                load;
  logic [X_W-1:0]      load_x;
  logic [Y_W-1:0]      load_y;
  pong_pkg::dir_t      load_dx;
  pong_pkg::dir_t      load_dy;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  pong_pkg::dir_t      dir_x;
  pong_pkg::dir_t      dir_y;
  logic                step;
  logic                bounce_x;
  logic                bounce_y;
`ifdef TRAJ_BOUNCE_COUNT_EN
  logic [pong_pkg::BOUNCE_CNT_W-1:0] bounce_count;
`endif

  modport master (
    output active, threshold, load, load_x, load_y, load_dx, load_dy,
`ifdef TRAJ_BOUNCE_COUNT_EN
    input  bounce_count,
`endif
    input  x, y, dir_x, dir_y, step, bounce_x, bounce_y
  );

  modport slave (
    input  active, threshold, load, load_x, load_y, load_dx, load_dy,
`ifdef TRAJ_BOUNCE_COUNT_EN
    output bounce_count,
`endif
    output x, y, dir_x, dir_y, step, bounce_x, bounce_y
  );

endinterface

// File: rtl/axis_reflect.sv
// One axis of ball motion: steps pos by one toward dir, reflecting at 0 and MAX.
// Ports: clock, reset_n (sync, active-low), step_en, load, load_pos (pre-clamped),
//        load_dir -> pos, dir, bounce (all registered).
module axis_reflect
  import pong_pkg::*;
#(
  parameter int unsigned W   = 9,
  parameter int unsigned MAX = 319
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         step_en,
  input  logic         load,
  input  logic [W-1:0] load_pos,
  input  dir_t         load_dir,
  output logic [W-1:0] pos,
  output dir_t         dir,
  output logic         bounce
);

  localparam logic [W-1:0] MAX_V   = W'(MAX);
  localparam logic [W-1:0] RESET_V = W'(MAX / 2);

  logic [W-1:0] pos_q, pos_d;
  dir_t         dir_q, dir_d;
  logic         bounce_q, bounce_d;

  // Next position; a reflection consumes the step so pos never dwells on an edge
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    if (load) begin
      pos_d = load_pos;
      dir_d = load_dir;
    end else if (step_en) begin
      if (dir_q == DIR_INC) begin
        if (pos_q == MAX_V) begin
          pos_d    = MAX_V - W'(1);
          dir_d    = DIR_DEC;
          bounce_d = 1'b1;
        end else begin
          pos_d = pos_q + W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d    = W'(1);
          dir_d    = DIR_INC;
          bounce_d = 1'b1;
        end else begin
          pos_d = pos_q - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pos_q    <= RESET_V;
      dir_q    <= DIR_INC;
      bounce_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
    end
  end

  assign pos    = pos_q;
  assign dir    = dir_q;
  assign bounce = bounce_q;

endmodule

// File: rtl/ball_trajectory_2d.sv
// Two-axis ball trajectory: moves (x, y) one unit per axis every threshold+1
// active cycles, reflecting at the playfield edges and pulsing step/bounce.
// Ports: clock, reset_n (sync, active-low), bus (ball_trajectory_2d_if.slave):
//   active, threshold, load, load_x/y, load_dx/dy in; x, y, dir_x/y, step,
//   bounce_x/y out (registered).
// TRAJ_BOUNCE_COUNT_EN adds bus.bounce_count: saturating x-bounce count,
// cleared by reset and load.
module ball_trajectory_2d
  import pong_pkg::*;
#(
  parameter int unsigned X_W   = 9,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned X_MAX = PF_X_MAX,
  parameter int unsigned Y_MAX = PF_Y_MAX,
  parameter int unsigned TH_W  = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ball_trajectory_2d_if.slave  bus
);

  localparam logic [X_W-1:0] X_MAX_V = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_V = Y_W'(Y_MAX);

  logic [TH_W-1:0] cnt_q, cnt_d;
  logic            step_q, step_d;
  logic [X_W-1:0]  load_x_c;
  logic [Y_W-1:0]  load_y_c;

  // Serve coordinates are clamped into the playfield
  always_comb begin
    load_x_c = (bus.load_x > X_MAX_V) ? X_MAX_V : bus.load_x;
    load_y_c = (bus.load_y > Y_MAX_V) ? Y_MAX_V : bus.load_y;
  end

  // Tick counter; >= so a lowered threshold fires next edge instead of wrapping
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (bus.load) begin
      cnt_d = '0;
    end else if (bus.active) begin
      if (cnt_q >= bus.threshold) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + TH_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign bus.step = step_q;

  axis_reflect #(.W(X_W), .MAX(X_MAX)) u_axis_x (
    .clock    (clock),
    .reset_n  (reset_n),
    .step_en  (step_d),
    .load     (bus.load),
    .load_pos (load_x_c),
    .load_dir (bus.load_dx),
    .pos      (bus.x),
    .dir      (bus.dir_x),
    .bounce   (bus.bounce_x)
  );

  axis_reflect #(.W(Y_W), .MAX(Y_MAX)) u_axis_y (
    .clock    (clock),
    .reset_n  (reset_n),
    .step_en  (step_d),
    .load     (bus.load),
    .load_pos (load_y_c),
    .load_dir (bus.load_dy),
    .pos      (bus.y),
    .dir      (bus.dir_y),
    .bounce   (bus.bounce_y)
  );

`ifdef TRAJ_BOUNCE_COUNT_EN
  logic [BOUNCE_CNT_W-1:0] bcnt_q, bcnt_d;
  logic                    bounce_x_c;

  // Predict the x reflection so the count lands on the same edge as bounce_x
  always_comb begin
    bounce_x_c = step_d && ((bus.dir_x == DIR_INC) ? (bus.x == X_MAX_V) : (bus.x == '0));
    bcnt_d     = bcnt_q;
    if (bus.load) begin
      bcnt_d = '0;
    end else if (bounce_x_c && (bcnt_q != {BOUNCE_CNT_W{1'b1}})) begin
      bcnt_d = bcnt_q + BOUNCE_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign bus.bounce_count = bcnt_q;
`endif

endmodule

// File: tb/tb_ball_trajectory_2d.sv
// Self-checking bench for ball_trajectory_2d: load-clamp vector table, directed
// corner sequences and randomized stimulus against a behavioural model.
// Honours TRAJ_BOUNCE_COUNT_EN when the design is built with it.
module tb_ball_trajectory_2d;

  localparam int XM = 319;
  localparam int YM = 239;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  ball_trajectory_2d_if #(.X_W(9), .Y_W(9), .TH_W(64)) bus ();

  ball_trajectory_2d dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int              mx, my, mdx, mdy, mstep, mbx, mby, mbc;
  longint unsigned mcnt;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Move one coordinate one unit, reflecting off 0 and max
  task automatic axis_move(inout int pos, inout int dir, input int max, output int b);
    b = 0;
    if (dir == 1) begin
      if (pos == max) begin dir = 0; pos = max - 1; b = 1; end
      else pos = pos + 1;
    end else begin
      if (pos == 0) begin dir = 1; pos = 1; b = 1; end
      else pos = pos - 1;
    end
  endtask

  task automatic model_edge();
    mstep = 0; mbx = 0; mby = 0;
    if (!reset_n) begin
      mx = XM / 2; my = YM / 2; mdx = 1; mdy = 1; mcnt = 0; mbc = 0;
    end else if (bus.load) begin
      mx   = (int'(bus.load_x) > XM) ? XM : int'(bus.load_x);
      my   = (int'(bus.load_y) > YM) ? YM : int'(bus.load_y);
      mdx  = int'(bus.load_dx);
      mdy  = int'(bus.load_dy);
      mcnt = 0;
      mbc  = 0;
    end else if (bus.active) begin
      if (mcnt >= longint'(bus.threshold)) begin
        mcnt  = 0;
        mstep = 1;
        axis_move(mx, mdx, XM, mbx);
        axis_move(my, mdy, YM, mby);
        if (mbx == 1 && mbc < 65535) mbc++;
      end else begin
        mcnt++;
      end
    end
  endtask

  // One clock edge: advance model, compare every output
  task automatic tick();
    @(posedge clock);
    #1;
    model_edge();
    chk("x", bus.x, mx);
    chk("y", bus.y, my);
    chk("dir_x", bus.dir_x, mdx);
    chk("dir_y", bus.dir_y, mdy);
    chk("step", bus.step, mstep);
    chk("bounce_x", bus.bounce_x, mbx);
    chk("bounce_y", bus.bounce_y, mby);
`ifdef TRAJ_BOUNCE_COUNT_EN
    chk("bounce_count", bus.bounce_count, mbc);
`endif
  endtask

  task automatic serve(input int lx, input int ly, input int ldx, input int ldy);
    bus.load_x  = 9'(lx);
    bus.load_y  = 9'(ly);
    bus.load_dx = 1'(ldx);
    bus.load_dy = 1'(ldy);
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  typedef struct {
    int lx, ly, ldx, ldy;
    int ex, ey;
  } load_vec_t;

  load_vec_t lv[6];

  int steps, bxs;

  initial begin
    lv[0] = '{lx: 500, ly: 5,   ldx: 1, ldy: 0, ex: 319, ey: 5};
    lv[1] = '{lx: 10,  ly: 20,  ldx: 0, ldy: 1, ex: 10,  ey: 20};
    lv[2] = '{lx: 0,   ly: 300, ldx: 1, ldy: 1, ex: 0,   ey: 239};
    lv[3] = '{lx: 511, ly: 511, ldx: 0, ldy: 0, ex: 319, ey: 239};
    lv[4] = '{lx: 319, ly: 239, ldx: 1, ldy: 0, ex: 319, ey: 239};
    lv[5] = '{lx: 320, ly: 240, ldx: 0, ldy: 1, ex: 319, ey: 239};

    reset_n       = 1'b0;
    bus.active    = 1'b0;
    bus.threshold = '0;
    bus.load      = 1'b0;
    bus.load_x    = '0;
    bus.load_y    = '0;
    bus.load_dx   = 1'b0;
    bus.load_dy   = 1'b0;
    tick();
    tick();

    // Reset state, then idle for 100 cycles
    reset_n = 1'b1;
    steps = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      steps += int'(bus.step) + int'(bus.bounce_x) + int'(bus.bounce_y);
    end
    chk("idle_x", bus.x, 159);
    chk("idle_y", bus.y, 119);
    chk("idle_dir_x", bus.dir_x, 1);
    chk("idle_dir_y", bus.dir_y, 1);
    chk("idle_pulses", steps, 0);

    // Period of threshold+1 cycles
    bus.threshold = 64'd4;
    bus.active    = 1'b1;
    steps = 0;
    for (int i = 0; i < 4; i++) begin tick(); steps += int'(bus.step); end
    chk("th4_no_early_step", steps, 0);
    tick();
    chk("th4_step1", bus.step, 1);
    chk("th4_x1", bus.x, 160);
    chk("th4_y1", bus.y, 120);
    steps = 0;
    for (int i = 0; i < 5; i++) begin tick(); steps += int'(bus.step); end
    chk("th4_steps2", steps, 1);
    chk("th4_x2", bus.x, 161);

    // Load-clamp table; active low to show load is independent of active
    bus.active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      serve(lv[i].lx, lv[i].ly, lv[i].ldx, lv[i].ldy);
      chk("tbl_x", bus.x, lv[i].ex);
      chk("tbl_y", bus.y, lv[i].ey);
      chk("tbl_dir_x", bus.dir_x, lv[i].ldx);
      chk("tbl_dir_y", bus.dir_y, lv[i].ldy);
      chk("tbl_step", bus.step, 0);
    end

    // Edge reflection on both axes at threshold 0
    bus.threshold = '0;
    bus.active    = 1'b1;
    serve(318, 5, 1, 0);
    tick();
    chk("ref_x319", bus.x, 319);
    chk("ref_y4", bus.y, 4);
    tick();
    chk("ref_x318", bus.x, 318);
    chk("ref_bx", bus.bounce_x, 1);
    chk("ref_dir_x0", bus.dir_x, 0);
    tick(); tick(); tick();
    chk("ref_y0", bus.y, 0);
    chk("ref_by0", bus.bounce_y, 0);
    tick();
    chk("ref_y1", bus.y, 1);
    chk("ref_by", bus.bounce_y, 1);
    chk("ref_dir_y1", bus.dir_y, 1);

    // Corner: both axes reflect on the same step
    serve(319, 239, 1, 1);
    tick();
    chk("corner_x", bus.x, 318);
    chk("corner_y", bus.y, 238);
    chk("corner_bx", bus.bounce_x, 1);
    chk("corner_by", bus.bounce_y, 1);
    chk("corner_dx", bus.dir_x, 0);
    chk("corner_dy", bus.dir_y, 0);

    // Lowering threshold mid-count steps on the next edge
    bus.threshold = 64'd1000;
    serve(500, 100, 0, 1);
    chk("clamp_x", bus.x, 319);
    steps = 0;
    for (int i = 0; i < 600; i++) begin tick(); steps += int'(bus.step); end
    chk("th1000_no_step", steps, 0);
    bus.threshold = 64'd10;
    tick();
    chk("th_drop_step", bus.step, 1);
    chk("th_drop_x", bus.x, 318);
    steps = 0;
    for (int i = 0; i < 10; i++) begin tick(); steps += int'(bus.step); end
    chk("th10_gap", steps, 0);
    tick();
    chk("th10_step", bus.step, 1);

    // Reset beats a simultaneous load
    bus.threshold = '0;
    tick(); tick();
    reset_n     = 1'b0;
    bus.load_x  = 9'd5;
    bus.load_y  = 9'd5;
    bus.load_dx = 1'b0;
    bus.load_dy = 1'b0;
    bus.load    = 1'b1;
    tick();
    bus.load = 1'b0;
    reset_n  = 1'b1;
    chk("rst_ld_x", bus.x, 159);
    chk("rst_ld_y", bus.y, 119);
    chk("rst_ld_dx", bus.dir_x, 1);
    chk("rst_ld_step", bus.step, 0);

    // Three x reflections after a serve
    serve(319, 100, 1, 1);
`ifdef TRAJ_BOUNCE_COUNT_EN
    chk("bcnt_after_load", bus.bounce_count, 0);
`endif
    bxs = 0;
    for (int i = 0; i < 639; i++) begin tick(); bxs += int'(bus.bounce_x); end
    chk("three_bx", bxs, 3);
`ifdef TRAJ_BOUNCE_COUNT_EN
    chk("bcnt_three", bus.bounce_count, 3);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 299) != 0);
      bus.active = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) bus.threshold = 64'($urandom_range(0, 3));
      bus.load = ($urandom_range(0, 39) == 0);
      bus.load_x  = $urandom_range(0, 1) ? 9'($urandom_range(0, 4)) : 9'($urandom_range(315, 511));
      bus.load_y  = $urandom_range(0, 1) ? 9'($urandom_range(0, 4)) : 9'($urandom_range(235, 511));
      bus.load_dx = 1'($urandom_range(0, 1));
      bus.load_dy = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_trajectory_2d.md
Name: ball_trajectory_2d

Overview:
- Two-axis successor to the single-axis trajectory block: moves a ball position (x, y) by one unit per axis every THRESHOLD+1 clock cycles while active.
- Reflects direction at the playfield edges (0 and X_MAX/Y_MAX) and reports each bounce.
- Sits between the game controller (serve/load, speed via threshold) and the pixel renderer/collision logic in the pong datapath.

Parameters:
- X_W, 9, x coordinate width in bits
- Y_W, 9, y coordinate width in bits
- X_MAX, 319, rightmost legal x (must satisfy 1 <= X_MAX < 2**X_W)
- Y_MAX, 239, bottom legal y (must satisfy 1 <= Y_MAX < 2**Y_W)
- TH_W, 64, threshold/tick-counter width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- active  in  1  1 = motion enabled; 0 = freeze position and tick counter
- threshold  in  TH_W  step period minus one, in cycles
- load  in  1  one-cycle serve strobe: load position/direction
- load_x  in  X_W  serve x
- load_y  in  Y_W  serve y
- load_dx  in  1  serve x direction (1 = increasing)
- load_dy  in  1  serve y direction (1 = increasing)
- x  out  X_W  current x
- y  out  Y_W  current y
- dir_x  out  1  current x direction
- dir_y  out  1  current y direction
- step  out  1  one-cycle pulse on each move
- bounce_x  out  1  one-cycle pulse when x reflected
- bounce_y  out  1  one-cycle pulse when y reflected

Behaviour:
- Reset (reset_n=0 at edge):
  - x=X_MAX/2, y=Y_MAX/2 (integer floor)
  - dir_x=1, dir_y=1
  - tick counter=0
  - step=bounce_x=bounce_y=0
  - Reset overrides load and active.
- Priority per edge: reset > load > active stepping > hold.
- load=1:
  - x=min(load_x,X_MAX), y=min(load_y,Y_MAX), dir_x=load_dx, dir_y=load_dy
  - counter cleared; no step/bounce pulse that cycle
  - load works regardless of active.
- Tick counter, when active=1 and no load:
  - if counter >= threshold: counter<=0 and step taken this edge
  - else counter<=counter+1
  - threshold=0 therefore steps every cycle.
  - The >= compare means a threshold lowered mid-count steps on the next edge, never wraps the counter.
- active=0: counter, position and directions hold; pulses 0.
- Per-axis step (x shown; y identical with Y_MAX):
  - dir_x=1, x<X_MAX: x<=x+1
  - dir_x=1, x==X_MAX: dir_x<=0, x<=X_MAX-1, bounce_x=1
  - dir_x=0, x>0: x<=x-1
  - dir_x=0, x==0: dir_x<=1, x<=1, bounce_x=1
- Position never leaves [0, MAX]; a reflection consumes the step (no dwell at the edge).
- Corner: both axes bounce on the same step; bounce_x and bounce_y both pulse.
- Timing:
  - Outputs are registered; step/bounce pulses assert in the same cycle the new position is visible, for exactly one cycle.
  - Latency from step-qualifying edge to updated x/y: 0 cycles after that edge (registered output).

Optional Feature:
- Macro: TRAJ_BOUNCE_COUNT_EN.
- Defined:
  - Adds output port bounce_count (16 bits): number of x bounces since reset or last load (load clears it), saturating at 16'hFFFF.
  - Increments on the same edge bounce_x is asserted.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Package pong_pkg:
  - typedef dir_t (1 = increasing, 0 = decreasing)
  - constants DIR_INC/DIR_DEC
  - default playfield constants PF_X_MAX=319, PF_Y_MAX=239
- Natural sub-module axis_reflect:
  - parameters W and MAX
  - inputs: clock, reset_n, step_en, load, load_pos, load_dir
  - outputs: pos, dir, bounce
  - instantiated twice; the top owns the tick counter and load clamping.

Test Plan:
- Reset then active=0 for 100 cycles -> x=159, y=119, dir_x=dir_y=1, no pulses.
- threshold=4, active=1 -> step pulses every 5 cycles; x 159->160->161, y 119->120.
- load x=318, y=5, dx=1, dy=0, threshold=0 -> next steps: x 319, then x 318 with bounce_x and dir_x=0; y 4,3,2,1,0, then 1 with bounce_y.
- load x=319, y=239, dx=1, dy=1, threshold=0 -> first step: x=318, y=238, both bounce pulses in the same cycle, both dirs 0.
- threshold=1000 with counter at 600, change threshold to 10 -> step on the next edge, counter back to 0, subsequent period 11 cycles; load x=500 -> x clamped to 319.
- Assert reset_n=0 mid-motion, same cycle as load=1 -> reset values win; with TRAJ_BOUNCE_COUNT_EN, bounce_count=0 after reset and after load, 3 x-bounces -> 3.
